// File: rtl/descrambler.sv
// descrambler: per-lane PCIe RX descrambler for 8b/10b (Gen1/2) and 128b/130b (Gen3+) symbols.
// Control symbols and sync headers pass through; every output is registered once.
module descrambler (
    input  logic        clk,
    input  logic        reset,
    input  logic        turnOff,
    input  logic        PIPEDataValid,
    input  logic [5:0]  PIPEWIDTH,
    input  logic [1:0]  PIPESyncHeader,
    input  logic [23:0] seedValue,
    input  logic [31:0] PIPEData,
    input  logic [3:0]  PIPEDataK,
    output logic        descramblerDataValid,
    output logic [31:0] descramblerData,
    output logic [3:0]  descramblerDataK,
    output logic [1:0]  descramblerSyncHeader
);
    localparam logic [7:0]  COM    = 8'hBC;
    localparam logic [7:0]  SKP    = 8'h1C;
    localparam logic [15:0] TAPS16 = 16'h0039;
    localparam logic [22:0] TAPS23 = 23'h210125;

    logic [15:0] lfsr16, lfsr16_nxt;
    logic [22:0] lfsr23, lfsr23_nxt;
    logic [3:0]  sym_cnt, sym_cnt_nxt;
    logic [1:0]  blk_type, blk_cur;
    logic        gen3, blk_start;
    logic [2:0]  nbytes;
    logic [3:0]  lane_en;
    logic [31:0] byte_mask, descr;
    logic [23:0] k16;
    logic [30:0] k23;
    logic [7:0]  sym;
    logic        is_k;
    logic        seed_unused;

    assign seed_unused = seedValue[23];

    // Galois step, MSB out first; returns {next state, key byte LSB-first}
    function automatic logic [23:0] adv16(input logic [15:0] s);
        logic [15:0] l;
        logic [7:0]  k;
        l = s;
        k = '0;
        for (int i = 0; i < 8; i++) begin
            k[i] = l[15];
            l = {l[14:0], 1'b0} ^ (l[15] ? TAPS16 : 16'h0000);
        end
        return {l, k};
    endfunction

    function automatic logic [30:0] adv23(input logic [22:0] s);
        logic [22:0] l;
        logic [7:0]  k;
        l = s;
        k = '0;
        for (int i = 0; i < 8; i++) begin
            k[i] = l[22];
            l = {l[21:0], 1'b0} ^ (l[22] ? TAPS23 : 23'h000000);
        end
        return {l, k};
    endfunction

    always_comb begin
        nbytes      = PIPEWIDTH == 6'd32 ? 3'd4 : PIPEWIDTH == 6'd16 ? 3'd2 : 3'd1;
        lane_en     = PIPEWIDTH == 6'd32 ? 4'hF : PIPEWIDTH == 6'd16 ? 4'h3 : 4'h1;
        byte_mask   = {{8{lane_en[3]}}, {8{lane_en[2]}}, {8{lane_en[1]}}, {8{lane_en[0]}}};
        gen3        = PIPESyncHeader != 2'b00;
        blk_start   = sym_cnt == 4'd0;
        blk_cur     = blk_start ? PIPESyncHeader : blk_type;
        sym_cnt_nxt = gen3 ? sym_cnt + {1'b0, nbytes} : 4'd0;
    end

    // LFSR state is chained byte by byte so a COM resets the key for later bytes of the same beat
    always_comb begin
        lfsr16_nxt = lfsr16;
        lfsr23_nxt = lfsr23;
        descr      = PIPEData;
        k16        = '0;
        k23        = '0;
        sym        = '0;
        is_k       = 1'b0;
        for (int b = 0; b < 4; b++) begin
            sym  = PIPEData[8*b +: 8];
            is_k = PIPEDataK[b];
            k16  = adv16(lfsr16_nxt);
            k23  = adv23(lfsr23_nxt);
            if (lane_en[b] && !gen3) begin
                if (is_k && sym == COM)
                    lfsr16_nxt = 16'hFFFF;
                else if (!(is_k && sym == SKP)) begin
                    lfsr16_nxt = k16[23:8];
                    descr[8*b +: 8] = is_k ? sym : sym ^ k16[7:0];
                end
            end else if (lane_en[b] && blk_cur == 2'b10) begin
                lfsr23_nxt = k23[30:8];
                descr[8*b +: 8] = sym ^ k23[7:0];
            end
        end
        if (gen3 && blk_start && PIPESyncHeader == 2'b01 && PIPEData[7:0] == 8'h00)
            lfsr23_nxt = seedValue[22:0];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lfsr16                <= 16'hFFFF;
            lfsr23                <= seedValue[22:0];
            sym_cnt               <= '0;
            blk_type              <= '0;
            descramblerDataValid  <= 1'b0;
            descramblerData       <= '0;
            descramblerDataK      <= '0;
            descramblerSyncHeader <= '0;
        end else begin
            descramblerDataValid  <= PIPEDataValid;
            descramblerSyncHeader <= PIPESyncHeader;
            descramblerData       <= (turnOff ? PIPEData : descr) & byte_mask;
            descramblerDataK      <= PIPEDataK & lane_en;
            if (PIPEDataValid) begin
                lfsr16  <= lfsr16_nxt;
                lfsr23  <= lfsr23_nxt;
                sym_cnt <= sym_cnt_nxt;
                if (gen3 && blk_start)
                    blk_type <= PIPESyncHeader;
            end
        end
    end
endmodule

// File: tb/tb_descrambler.sv
// tb_descrambler: directed stimulus for descrambler, checked every cycle against a keystream-index model
// plus hand-computed literal expectations.
module tb_descrambler;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        turnOff = 1'b0;
    logic        PIPEDataValid = 1'b0;
    logic [5:0]  PIPEWIDTH = 6'd32;
    logic [1:0]  PIPESyncHeader = 2'b00;
    logic [23:0] seedValue = '0;
    logic [31:0] PIPEData = '0;
    logic [3:0]  PIPEDataK = '0;
    logic        descramblerDataValid;
    logic [31:0] descramblerData;
    logic [3:0]  descramblerDataK;
    logic [1:0]  descramblerSyncHeader;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    descrambler dut (
        .clk(clk), .reset(reset), .turnOff(turnOff), .PIPEDataValid(PIPEDataValid),
        .PIPEWIDTH(PIPEWIDTH), .PIPESyncHeader(PIPESyncHeader), .seedValue(seedValue),
        .PIPEData(PIPEData), .PIPEDataK(PIPEDataK),
        .descramblerDataValid(descramblerDataValid), .descramblerData(descramblerData),
        .descramblerDataK(descramblerDataK), .descramblerSyncHeader(descramblerSyncHeader)
    );

    // Gen1 keystream as a bit stream obeying s[n+16] = s[n+5]^s[n+4]^s[n+3]^s[n]
    logic        g1_bits [0:4159];
    logic [7:0]  g1_ks   [0:519];
    logic [15:0] init16;
    int          g1_idx, g3_idx, pos;
    logic [22:0] g3_seed;
    logic [1:0]  blk_m;
    logic        exp_v;
    logic [1:0]  exp_sh;
    logic [31:0] exp_d;
    logic [3:0]  exp_k;

    function automatic logic [7:0] g3_key(input logic [22:0] seed, input int n);
        logic [22:0] l;
        logic [7:0]  k;
        l = seed;
        k = '0;
        for (int i = 0; i < 8 * n + 8; i++) begin
            if (i >= 8 * n) k[i - 8 * n] = l[22];
            l = {l[21:0], 1'b0} ^ (l[22] ? 23'h210125 : 23'h0);
        end
        return k;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        g1_idx = 0; g3_idx = 0; pos = 0; blk_m = 2'b00;
        g3_seed = seedValue[22:0];
        exp_v = 1'b0; exp_sh = 2'b00; exp_d = '0; exp_k = '0;
    endtask

    task automatic model_step();
        int n;
        logic g3;
        logic [1:0] bt;
        logic [7:0] s, o;
        exp_v = PIPEDataValid; exp_sh = PIPESyncHeader; exp_d = '0; exp_k = '0;
        if (!PIPEDataValid) return;
        n  = PIPEWIDTH == 6'd32 ? 4 : PIPEWIDTH == 6'd16 ? 2 : 1;
        g3 = PIPESyncHeader != 2'b00;
        if (!g3) pos = 0;
        bt = pos == 0 ? PIPESyncHeader : blk_m;
        if (g3 && pos == 0) blk_m = PIPESyncHeader;
        for (int b = 0; b < n; b++) begin
            s = PIPEData[8*b +: 8];
            o = s;
            if (!g3) begin
                if (PIPEDataK[b] && s == 8'hBC) g1_idx = 0;
                else if (!(PIPEDataK[b] && s == 8'h1C)) begin
                    if (!PIPEDataK[b]) o = s ^ g1_ks[g1_idx];
                    g1_idx++;
                end
            end else if (bt == 2'b10) begin
                o = s ^ g3_key(g3_seed, g3_idx);
                g3_idx++;
            end
            exp_d[8*b +: 8] = turnOff ? s : o;
            exp_k[b] = PIPEDataK[b];
        end
        if (g3 && bt == 2'b01 && pos == 0 && PIPEData[7:0] == 8'h00) begin
            g3_seed = seedValue[22:0];
            g3_idx  = 0;
        end
        if (g3) pos = (pos + n) % 16;
    endtask

    always @(posedge clk) begin
        if (!reset) model_reset(); else model_step();
        #1;
        chk("valid", {31'b0, descramblerDataValid}, {31'b0, exp_v});
        chk("sync", {30'b0, descramblerSyncHeader}, {30'b0, exp_sh});
        if (exp_v) begin
            chk("data", descramblerData, exp_d);
            chk("k", {28'b0, descramblerDataK}, {28'b0, exp_k});
        end
    end

    task automatic beat(input logic [31:0] d, input logic [3:0] k);
        @(negedge clk);
        PIPEData = d; PIPEDataK = k; PIPEDataValid = 1'b1;
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        @(negedge clk);
        PIPEDataValid = 1'b0; PIPEData = $urandom;
        @(posedge clk);
        #2;
    endtask

    initial begin
        logic [7:0] pin [8];
        logic [31:0] d;
        logic [3:0]  k;
        pin = '{8'hFF, 8'h17, 8'hC0, 8'h14, 8'hB2, 8'hE7, 8'h02, 8'h82};
        init16 = 16'h17FF;
        for (int i = 0; i < 16; i++) g1_bits[i] = init16[i];
        for (int i = 0; i < 4144; i++)
            g1_bits[i+16] = g1_bits[i+5] ^ g1_bits[i+4] ^ g1_bits[i+3] ^ g1_bits[i];
        for (int m = 0; m < 520; m++)
            for (int j = 0; j < 8; j++) g1_ks[m][j] = g1_bits[8*m+j];
        for (int i = 0; i < 8; i++) chk($sformatf("ks%0d", i), {24'b0, g1_ks[i]}, {24'b0, pin[i]});
        chk("g3key_seed0", {24'b0, g3_key(23'h0, 5)}, 32'h0);
        chk("g3key_msb", {24'b0, g3_key(23'h400000, 0)}, 32'hD5);

        repeat (2) @(negedge clk);
        chk("rst_data", descramblerData, 32'h0);
        reset = 1'b1;

        // Gen1: COM, data, SKP, bypass
        beat(32'h000000BC, 4'b0001);
        chk("com_data", descramblerData, 32'hC017FFBC);
        chk("com_k", {28'b0, descramblerDataK}, 32'h1);
        beat(32'h0, 4'b0000);
        chk("after_com", descramblerData, 32'h02E7B214);
        idle();
        beat(32'h001C1CBC, 4'b0111);
        chk("skp", descramblerData, 32'hFF1C1CBC);
        turnOff = 1'b1;
        beat(32'h2525AAAA, 4'b0000);
        chk("bypass", descramblerData, 32'h2525AAAA);
        chk("bypass_v", {31'b0, descramblerDataValid}, 32'h1);
        turnOff = 1'b0;
        beat(32'h0, 4'b0000);
        chk("bypass_resume", {16'b0, descramblerData[15:0]}, 32'h02E7);

        // width 8, upper bytes masked
        PIPEWIDTH = 6'd8;
        beat(32'hAABBCCBC, 4'b1111);
        chk("w8_com", descramblerData, 32'h000000BC);
        chk("w8_k", {28'b0, descramblerDataK}, 32'h1);
        beat(32'hAABBCC00, 4'b1110);
        chk("w8_b1", descramblerData, 32'h000000FF);
        chk("w8_k0", {28'b0, descramblerDataK}, 32'h0);
        beat(32'h0, 4'b0000);
        chk("w8_b2", descramblerData, 32'h00000017);
        beat(32'h0, 4'b0000);
        chk("w8_b3", descramblerData, 32'h000000C0);

        // mixed widths and K patterns
        for (int i = 0; i < 24; i++) begin
            PIPEWIDTH = (i % 4 == 0) ? 6'd32 : (i % 4 == 1) ? 6'd16 : (i % 4 == 2) ? 6'd37 : 6'd8;
            d = $urandom;
            k = 4'(i % 3 == 0 ? 4'b0100 : 4'b0000);
            if (i % 5 == 0) begin d[8*(i%4) +: 8] = 8'hBC; k[i%4] = 1'b1; end
            if (i % 7 == 0) begin d[8*((i+1)%4) +: 8] = 8'h1C; k[(i+1)%4] = 1'b1; end
            beat(d, k);
            if (i % 6 == 5) idle();
        end

        // Gen3, seed 0: EIEOS block then zero data block
        PIPEWIDTH = 6'd32; seedValue = '0; PIPESyncHeader = 2'b01;
        beat(32'hFFFFFF00, 4'b0000);
        chk("eieos", descramblerData, 32'hFFFFFF00);
        chk("eieos_sh", {30'b0, descramblerSyncHeader}, 32'h1);
        repeat (3) beat(32'h00FF00FF, 4'b0000);
        chk("os_pass", descramblerData, 32'h00FF00FF);
        PIPESyncHeader = 2'b10;
        for (int i = 0; i < 4; i++) begin
            beat(32'h0, 4'b0000);
            chk("g3_seed0", descramblerData, 32'h0);
        end
        chk("g3_sh", {30'b0, descramblerSyncHeader}, 32'h2);

        // Gen3, lane seed, width 16 data block, non-EIEOS OS block
        seedValue = 24'h1DBFBC; PIPESyncHeader = 2'b01;
        beat(32'hFFFFFF00, 4'b0000);
        repeat (3) beat(32'hFFFFFFFF, 4'b0000);
        PIPESyncHeader = 2'b10;
        repeat (4) beat(32'h0, 4'b0000);
        PIPEWIDTH = 6'd16;
        for (int i = 0; i < 8; i++) begin
            beat($urandom, 4'b0000);
            if (i == 3) idle();
        end
        PIPEWIDTH = 6'd32; PIPESyncHeader = 2'b01;
        repeat (4) beat(32'hAAAAAAAA, 4'b0000);
        PIPESyncHeader = 2'b10;
        repeat (2) beat($urandom, 4'b0000);
        PIPESyncHeader = 2'b00;
        beat(32'h0, 4'b0000);
        PIPESyncHeader = 2'b10;
        beat(32'h0, 4'b0000);
        turnOff = 1'b1;
        beat(32'h12345678, 4'b0000);
        chk("g3_bypass", descramblerData, 32'h12345678);
        turnOff = 1'b0;
        repeat (2) beat(32'h0, 4'b0000);

        // async reset mid-beat
        PIPESyncHeader = 2'b00; PIPEWIDTH = 6'd8; seedValue = 24'h0ABCDE;
        beat(32'h000000BC, 4'b0001);
        #1 reset = 1'b0;
        #1;
        chk("arst_data", descramblerData, 32'h0);
        chk("arst_v", {31'b0, descramblerDataValid}, 32'h0);
        chk("arst_k", {28'b0, descramblerDataK}, 32'h0);
        @(negedge clk);
        PIPEDataValid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        beat(32'h0, 4'b0000);
        chk("post_rst", descramblerData, 32'h000000FF);
        PIPEWIDTH = 6'd32; PIPESyncHeader = 2'b10;
        repeat (4) beat(32'h0, 4'b0000);
        idle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
